stack_ctrl_fsm: RTL and testbench
=================================

Name: stack_ctrl_fsm

Overview:
- Parametrised second-generation control FSM for the stack processor.
- Sequences fetch, decode and execute of the 22-opcode ISA plus HALT, and drives strobes to the IR, temp registers, ALU, data memory, data stack, routine stack and IP.
- Adds over the first generation:
  - registered data-stack and routine-stack pointers with full/empty;
  - ready handshakes on program and data memory;
  - conditional branches on CMP flags;
  - sticky fault trapping.

Parameters:
- DATA_W, 16, data path and stack word width
- OPND_W, 11, operand field width; OPND_W <= DATA_W
- OPC_W, 5, opcode field width
- DEPTH, 32, data stack entries
- RTN_DEPTH, 16, routine stack entries
- PTR_W, 6, data stack pointer width; must hold DEPTH
- RPTR_W, 5, routine pointer width; must hold RTN_DEPTH

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instruction  in  OPC_W  opcode from IR
- operand  in  OPND_W  operand from IR
- mem_ready  in  1  program memory data valid
- memd_ready  in  1  data memory access complete
- data_out_memd  in  DATA_W  data memory read data
- temp1_q  in  DATA_W  temp1 register value
- alu_result  in  DATA_W  ALU output
- flag_eq, flag_gt, flag_lt  in  1 each  registered CMP flags
- stack_data  out  DATA_W  word to push
- rd_mem  out  1  program memory read strobe
- wr_ir  out  1  IR write strobe
- rd_memd, wr_memd  out  1 each  data memory strobes
- wr_temp1, wr_temp2, rd_temp1  out  1 each  temp register strobes
- alu_en  out  1  ALU execute strobe
- wr_ip, inc_ip  out  1 each  IP load / increment
- rd_ip  out  1  IP read strobe
- ip_src  out  1  IP load source: 0 = operand, 1 = routine stack
- push_stack, pop_stack  out  1 each  data stack strobes
- push_rtn, pop_rtn  out  1 each  routine stack strobes
- rst_all  out  1  reset to IR, temps, flags, IP and stacks
- tos_pointer  out  PTR_W  data stack occupancy
- rtn_pointer  out  RPTR_W  routine stack occupancy
- stack_full, stack_empty  out  1 each  data stack status
- halted  out  1  HALT executed
- fault  out  1  trap active
- fault_code  out  3  trap cause

Behaviour:
- Reset (rst asynchronous):
  - state = RESET_ALL; both pointers = 0; stack_data = 0; fault = 0; fault_code = 0; halted = 0.
  - All strobes are 0 except rst_all, which is 1 in RESET_ALL only.
  - rst asserted mid-instruction aborts immediately; no partial strobe survives.
- Strobes are combinational Moore outputs, default 0.
- Pointers, stack_data, halted and fault registers update on the clk edge.
- Pointer and status rules:
  - tos_pointer +1 on every push_stack cycle, -1 on every pop_stack cycle.
  - rtn_pointer updates the same way on push_rtn / pop_rtn.
  - stack_full = (tos_pointer == DEPTH); stack_empty = (tos_pointer == 0).
- State transitions:
  - RESET_ALL -> FETCH.
  - FETCH: rd_mem=1; hold until mem_ready, then -> LATCH_IR.
  - LATCH_IR: wr_ir=1 -> DECODE.
  - DECODE dispatch:
    - PUSH(0) -> READ_MEMD.
    - PUSH_I(1) -> PREP_IMM.
    - PUSH_T(2) -> PREP_TEMP.
    - POP(3), ADD..NOT(4-13) -> POP_A.
    - GOTO(14) -> JUMP.
    - IF_EQ..IF_LE(15-19) -> BRANCH.
    - CALL(20) -> PUSH_RTN.
    - RET(21) -> POP_RTN.
    - HALT(31) -> HALT.
    - any other opcode -> TRAP, code 5.
  - POP_A: pop_stack=1 -> SAVE_A.
    - POP -> WRITE_MEMD.
    - NOT -> EXEC.
    - others -> POP_B.
  - SAVE_A: wr_temp1=1.
  - POP_B: pop_stack=1 -> SAVE_B: wr_temp2=1 -> EXEC.
  - EXEC: alu_en=1.
    - CMP -> INC_IP.
    - else stack_data <= alu_result -> PUSH_RES.
  - PREP_IMM: stack_data <= zero-extended operand -> PUSH_RES.
  - PREP_TEMP: rd_temp1=1; stack_data <= temp1_q -> PUSH_RES.
  - READ_MEMD: rd_memd=1, address = operand.
    - Hold until memd_ready; then stack_data <= data_out_memd -> PUSH_RES.
  - WRITE_MEMD: wr_memd=1, hold until memd_ready -> INC_IP.
  - PUSH_RES: push_stack=1 -> INC_IP.
  - BRANCH: condition taken -> JUMP, else -> INC_IP.
    - EQ: flag_eq.
    - GT: flag_gt.
    - LT: flag_lt.
    - GE: flag_gt|flag_eq.
    - LE: flag_lt|flag_eq.
  - JUMP: wr_ip=1, ip_src=0 -> FETCH (no increment).
  - PUSH_RTN: push_rtn=1, rd_ip=1 -> JUMP.
  - POP_RTN: pop_rtn=1 -> LOAD_RET: wr_ip=1, ip_src=1 -> INC_IP.
  - INC_IP: inc_ip=1 -> FETCH.
- Guard checks happen in the state before the strobe. On failure, the strobe is not asserted and the FSM enters TRAP:
  - push with stack_full: code 1;
  - pop with stack_empty: code 2;
  - push_rtn with rtn_pointer == RTN_DEPTH: code 3;
  - pop_rtn with rtn_pointer == 0: code 4.
- Terminal states:
  - TRAP: fault=1; fault_code latched; all strobes 0; exits only on rst.
  - HALT: halted=1; all strobes 0; exits only on rst.
- Latency with both ready inputs tied high:
  - PUSH_I: 6 cycles, FETCH to the return to FETCH.
  - ADD: 10 cycles.
  - Each wait cycle adds 1.

Test Plan:
1. Reset, then PUSH_I operand=0x7FF, ready inputs high -> push_stack pulses in cycle 5 with stack_data=0x07FF; tos_pointer=1; inc_ip in cycle 6.
2. PUSH_I 3, PUSH_I 4, ADD with alu_result=7 -> two pops, wr_temp1 then wr_temp2, alu_en, push of 0x0007; tos_pointer ends at 1.
3. POP on empty stack -> no pop_stack; fault=1, fault_code=2, held for 20 cycles until rst clears all to 0.
4. DEPTH+1 successive PUSH_I -> the last push is suppressed; fault_code=1; tos_pointer=DEPTH; stack_full=1.
5. CALL operand=0x40, then RET -> push_rtn+rd_ip, then wr_ip with ip_src=0; later pop_rtn, wr_ip with ip_src=1, inc_ip; rtn_pointer 0->1->0.
6. PUSH with memd_ready low 3 cycles, data 0xBEEF -> rd_memd held 4 cycles, then push 0xBEEF.
7. IF_GE with flag_eq=1 -> wr_ip; with all flags 0 -> inc_ip.

Source files
------------

// File: rtl/stack_ctrl_fsm.sv
// Second-generation control FSM for the stack processor: sequences fetch/decode/execute,
// tracks data and routine stack occupancy, and traps stack misuse or unknown opcodes.
module stack_ctrl_fsm #(
  parameter int DATA_W    = 16,
  parameter int OPND_W    = 11,
  parameter int OPC_W     = 5,
  parameter int DEPTH     = 32,
  parameter int RTN_DEPTH = 16,
  parameter int PTR_W     = 6,
  parameter int RPTR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  instruction,
  input  logic [OPND_W-1:0] operand,
  input  logic              mem_ready,
  input  logic              memd_ready,
  input  logic [DATA_W-1:0] data_out_memd,
  input  logic [DATA_W-1:0] temp1_q,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              flag_eq,
  input  logic              flag_gt,
  input  logic              flag_lt,
  output logic [DATA_W-1:0] stack_data,
  output logic              rd_mem,
  output logic              wr_ir,
  output logic              rd_memd,
  output logic              wr_memd,
  output logic              wr_temp1,
  output logic              wr_temp2,
  output logic              rd_temp1,
  output logic              alu_en,
  output logic              wr_ip,
  output logic              inc_ip,
  output logic              rd_ip,
  output logic              ip_src,
  output logic              push_stack,
  output logic              pop_stack,
  output logic              push_rtn,
  output logic              pop_rtn,
  output logic              rst_all,
  output logic [PTR_W-1:0]  tos_pointer,
  output logic [RPTR_W-1:0] rtn_pointer,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        fault_code
);

  localparam logic [OPC_W-1:0] OP_PUSH   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_PUSH_I = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_PUSH_T = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_POP    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_CMP    = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_NOT    = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_GOTO   = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_IF_EQ  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_IF_GT  = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_IF_LT  = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_IF_GE  = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_IF_LE  = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_CALL   = OPC_W'(20);
  localparam logic [OPC_W-1:0] OP_RET    = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(31);

  typedef enum logic [4:0] {
    S_RESET_ALL, S_FETCH, S_LATCH_IR, S_DECODE, S_POP_A, S_SAVE_A, S_POP_B, S_SAVE_B,
    S_EXEC, S_PREP_IMM, S_PREP_TEMP, S_READ_MEMD, S_WRITE_MEMD, S_PUSH_RES, S_BRANCH,
    S_JUMP, S_PUSH_RTN, S_POP_RTN, S_LOAD_RET, S_INC_IP, S_TRAP, S_HALT
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_tos;
  logic [RPTR_W-1:0]   r_rtn;
  logic [DATA_W-1:0]   r_stack_data;
  logic                r_halted;
  logic                r_fault;
  logic [2:0]          r_fault_code;

  logic w_take;
  logic w_is_pop_op;
  logic w_is_branch;
  logic w_rtn_full;
  logic w_rtn_empty;

  assign w_is_pop_op = (instruction >= OP_POP) && (instruction <= OP_NOT);
  assign w_is_branch = (instruction >= OP_IF_EQ) && (instruction <= OP_IF_LE);
  assign w_rtn_full  = (r_rtn == RPTR_W'(RTN_DEPTH));
  assign w_rtn_empty = (r_rtn == '0);

  always_comb begin
    w_take = 1'b0;
    case (instruction)
      OP_IF_EQ: w_take = flag_eq;
      OP_IF_GT: w_take = flag_gt;
      OP_IF_LT: w_take = flag_lt;
      OP_IF_GE: w_take = flag_gt | flag_eq;
      OP_IF_LE: w_take = flag_lt | flag_eq;
      default:  w_take = 1'b0;
    endcase
  end

  // Guards are evaluated one state ahead so a failing strobe is never issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RESET_ALL;
      r_tos        <= '0;
      r_rtn        <= '0;
      r_stack_data <= '0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
    end else begin
      if (push_stack)     r_tos <= r_tos + PTR_W'(1);
      else if (pop_stack) r_tos <= r_tos - PTR_W'(1);
      if (push_rtn)       r_rtn <= r_rtn + RPTR_W'(1);
      else if (pop_rtn)   r_rtn <= r_rtn - RPTR_W'(1);

      case (r_state)
        S_RESET_ALL: r_state <= S_FETCH;
        S_FETCH:     if (mem_ready) r_state <= S_LATCH_IR;
        S_LATCH_IR:  r_state <= S_DECODE;
        S_DECODE: begin
          if (instruction == OP_PUSH)        r_state <= S_READ_MEMD;
          else if (instruction == OP_PUSH_I) r_state <= S_PREP_IMM;
          else if (instruction == OP_PUSH_T) r_state <= S_PREP_TEMP;
          else if (w_is_pop_op) begin
            if (stack_empty) begin
              r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd2;
            end else r_state <= S_POP_A;
          end
          else if (instruction == OP_GOTO) r_state <= S_JUMP;
          else if (w_is_branch)            r_state <= S_BRANCH;
          else if (instruction == OP_CALL) begin
            if (w_rtn_full) begin
              r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd3;
            end else r_state <= S_PUSH_RTN;
          end
          else if (instruction == OP_RET) begin
            if (w_rtn_empty) begin
              r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd4;
            end else r_state <= S_POP_RTN;
          end
          else if (instruction == OP_HALT) begin
            r_state <= S_HALT; r_halted <= 1'b1;
          end
          else begin
            r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd5;
          end
        end
        S_POP_A: r_state <= S_SAVE_A;
        S_SAVE_A: begin
          if (instruction == OP_POP)      r_state <= S_WRITE_MEMD;
          else if (instruction == OP_NOT) r_state <= S_EXEC;
          else if (stack_empty) begin
            r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd2;
          end else r_state <= S_POP_B;
        end
        S_POP_B:  r_state <= S_SAVE_B;
        S_SAVE_B: r_state <= S_EXEC;
        S_EXEC: begin
          if (instruction == OP_CMP) r_state <= S_INC_IP;
          else begin
            r_stack_data <= alu_result;
            if (stack_full) begin
              r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd1;
            end else r_state <= S_PUSH_RES;
          end
        end
        S_PREP_IMM, S_PREP_TEMP: begin
          r_stack_data <= (r_state == S_PREP_IMM) ? DATA_W'(operand) : temp1_q;
          if (stack_full) begin
            r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd1;
          end else r_state <= S_PUSH_RES;
        end
        S_READ_MEMD: begin
          if (memd_ready) begin
            r_stack_data <= data_out_memd;
            if (stack_full) begin
              r_state <= S_TRAP; r_fault <= 1'b1; r_fault_code <= 3'd1;
            end else r_state <= S_PUSH_RES;
          end
        end
        S_WRITE_MEMD: if (memd_ready) r_state <= S_INC_IP;
        S_PUSH_RES:   r_state <= S_INC_IP;
        S_BRANCH:     r_state <= w_take ? S_JUMP : S_INC_IP;
        S_JUMP:       r_state <= S_FETCH;
        S_PUSH_RTN:   r_state <= S_JUMP;
        S_POP_RTN:    r_state <= S_LOAD_RET;
        S_LOAD_RET:   r_state <= S_INC_IP;
        S_INC_IP:     r_state <= S_FETCH;
        S_TRAP:       r_state <= S_TRAP;
        S_HALT:       r_state <= S_HALT;
        default:      r_state <= S_TRAP;
      endcase
    end
  end

  assign rd_mem      = (r_state == S_FETCH);
  assign wr_ir       = (r_state == S_LATCH_IR);
  assign rd_memd     = (r_state == S_READ_MEMD);
  assign wr_memd     = (r_state == S_WRITE_MEMD);
  assign wr_temp1    = (r_state == S_SAVE_A);
  assign wr_temp2    = (r_state == S_SAVE_B);
  assign rd_temp1    = (r_state == S_PREP_TEMP);
  assign alu_en      = (r_state == S_EXEC);
  assign wr_ip       = (r_state == S_JUMP) || (r_state == S_LOAD_RET);
  assign inc_ip      = (r_state == S_INC_IP);
  assign rd_ip       = (r_state == S_PUSH_RTN);
  assign ip_src      = (r_state == S_LOAD_RET);
  assign push_stack  = (r_state == S_PUSH_RES);
  assign pop_stack   = (r_state == S_POP_A) || (r_state == S_POP_B);
  assign push_rtn    = (r_state == S_PUSH_RTN);
  assign pop_rtn     = (r_state == S_POP_RTN);
  assign rst_all     = (r_state == S_RESET_ALL);

  assign stack_data  = r_stack_data;
  assign tos_pointer = r_tos;
  assign rtn_pointer = r_rtn;
  assign stack_full  = (r_tos == PTR_W'(DEPTH));
  assign stack_empty = (r_tos == '0);
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Scoreboard bench for stack_ctrl_fsm: each issued instruction queues its expected
// per-cycle strobe pattern, which a negedge monitor pops and compares.
module tb_stack_ctrl_fsm;
  localparam int DEPTH     = 32;
  localparam int RTN_DEPTH = 16;

  localparam logic [4:0] OP_PUSH = 5'd0,  OP_PUSH_I = 5'd1,  OP_PUSH_T = 5'd2, OP_POP = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4,  OP_CMP    = 5'd12, OP_NOT    = 5'd13, OP_GOTO = 5'd14;
  localparam logic [4:0] OP_IF_EQ = 5'd15, OP_IF_GT = 5'd16, OP_IF_LT = 5'd17;
  localparam logic [4:0] OP_IF_GE = 5'd18, OP_IF_LE = 5'd19;
  localparam logic [4:0] OP_CALL = 5'd20, OP_RET = 5'd21, OP_HALT = 5'd31;

  localparam logic [16:0] B_RD_MEM  = 17'h10000, B_WR_IR   = 17'h08000, B_RD_MEMD = 17'h04000;
  localparam logic [16:0] B_WR_MEMD = 17'h02000, B_WR_T1   = 17'h01000, B_WR_T2   = 17'h00800;
  localparam logic [16:0] B_RD_T1   = 17'h00400, B_ALU_EN  = 17'h00200, B_WR_IP   = 17'h00100;
  localparam logic [16:0] B_INC_IP  = 17'h00080, B_RD_IP   = 17'h00040, B_IP_SRC  = 17'h00020;
  localparam logic [16:0] B_PUSH    = 17'h00010, B_POP     = 17'h00008, B_PUSH_R  = 17'h00004;
  localparam logic [16:0] B_POP_R   = 17'h00002, B_RST_ALL = 17'h00001;

  logic        clk, rst;
  logic [4:0]  instruction;
  logic [10:0] operand;
  logic        mem_ready, memd_ready;
  logic [15:0] data_out_memd, temp1_q, alu_result;
  logic        flag_eq, flag_gt, flag_lt;
  logic [15:0] stack_data;
  logic rd_mem, wr_ir, rd_memd, wr_memd, wr_temp1, wr_temp2, rd_temp1, alu_en;
  logic wr_ip, inc_ip, rd_ip, ip_src, push_stack, pop_stack, push_rtn, pop_rtn, rst_all;
  logic [5:0]  tos_pointer;
  logic [4:0]  rtn_pointer;
  logic        stack_full, stack_empty, halted, fault;
  logic [2:0]  fault_code;

  stack_ctrl_fsm #(
    .DATA_W(16), .OPND_W(11), .OPC_W(5), .DEPTH(DEPTH), .RTN_DEPTH(RTN_DEPTH), .PTR_W(6), .RPTR_W(5)
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .operand(operand),
    .mem_ready(mem_ready), .memd_ready(memd_ready), .data_out_memd(data_out_memd),
    .temp1_q(temp1_q), .alu_result(alu_result),
    .flag_eq(flag_eq), .flag_gt(flag_gt), .flag_lt(flag_lt),
    .stack_data(stack_data), .rd_mem(rd_mem), .wr_ir(wr_ir), .rd_memd(rd_memd), .wr_memd(wr_memd),
    .wr_temp1(wr_temp1), .wr_temp2(wr_temp2), .rd_temp1(rd_temp1), .alu_en(alu_en),
    .wr_ip(wr_ip), .inc_ip(inc_ip), .rd_ip(rd_ip), .ip_src(ip_src),
    .push_stack(push_stack), .pop_stack(pop_stack), .push_rtn(push_rtn), .pop_rtn(pop_rtn),
    .rst_all(rst_all), .tos_pointer(tos_pointer), .rtn_pointer(rtn_pointer),
    .stack_full(stack_full), .stack_empty(stack_empty), .halted(halted),
    .fault(fault), .fault_code(fault_code)
  );

  logic [16:0] w_strb;
  assign w_strb = {rd_mem, wr_ir, rd_memd, wr_memd, wr_temp1, wr_temp2, rd_temp1, alu_en,
                   wr_ip, inc_ip, rd_ip, ip_src, push_stack, pop_stack, push_rtn, pop_rtn, rst_all};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] strb;
    logic        chkd;
    logic [15:0] data;
  } sb_t;

  sb_t        q_exp[$];
  logic [1:0] q_drv[$];
  sb_t        mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_tos, m_rtn;
  logic       m_fault, m_halted;
  logic [2:0] m_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      mon_e = q_exp.pop_front();
      check({mon_e.tag, " strobes"}, 32'(w_strb), 32'(mon_e.strb));
      if (mon_e.chkd) check({mon_e.tag, " stack_data"}, 32'(stack_data), 32'(mon_e.data));
    end
  end

  task automatic sb_push(input string tag, input logic [16:0] strb, input logic mr,
                         input logic mdr, input logic chkd, input logic [15:0] data);
    sb_t e;
    e.tag = tag; e.strb = strb; e.chkd = chkd; e.data = data;
    q_exp.push_back(e);
    q_drv.push_back({mr, mdr});
  endtask

  task automatic drain();
    logic [1:0] d;
    while (q_drv.size() > 0) begin
      d = q_drv.pop_front();
      mem_ready = d[1]; memd_ready = d[0];
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; memd_ready = 1'b1;
    check("scoreboard drained", 32'(q_exp.size()), 32'd0);
  endtask

  task automatic trap(input logic [2:0] code);
    m_fault = 1'b1; m_code = code;
    repeat (3) sb_push("trap", 17'h0, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic inc_ip_cyc();
    sb_push("inc_ip", B_INC_IP, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic push_res(input logic [15:0] data);
    if (m_tos == DEPTH) trap(3'd1);
    else begin
      sb_push("push_res", B_PUSH, 1'b1, 1'b1, 1'b1, data);
      m_tos++;
      inc_ip_cyc();
    end
  endtask

  task automatic post_checks(input string tag);
    check({tag, " tos_pointer"}, 32'(tos_pointer), 32'(m_tos));
    check({tag, " rtn_pointer"}, 32'(rtn_pointer), 32'(m_rtn));
    check({tag, " stack_full"}, 32'(stack_full), 32'(m_tos == DEPTH));
    check({tag, " stack_empty"}, 32'(stack_empty), 32'(m_tos == 0));
    check({tag, " fault"}, 32'(fault), 32'(m_fault));
    check({tag, " fault_code"}, 32'(fault_code), 32'(m_code));
    check({tag, " halted"}, 32'(halted), 32'(m_halted));
  endtask

  // Called at the first cycle of FETCH; fw = fetch wait cycles, mw = data memory wait cycles.
  task automatic issue(input logic [4:0] opc, input logic [10:0] opnd, input int fw, input int mw);
    logic ok, take;
    string tag;
    tag = $sformatf("op%0d", opc);
    instruction = opc; operand = opnd;
    for (int i = 0; i < fw; i++) sb_push("fetch", B_RD_MEM, 1'b0, 1'b1, 1'b0, 16'h0);
    sb_push("fetch", B_RD_MEM, 1'b1, 1'b1, 1'b0, 16'h0);
    sb_push("latch_ir", B_WR_IR, 1'b1, 1'b1, 1'b0, 16'h0);
    sb_push("decode", 17'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    if (opc == OP_PUSH) begin
      for (int i = 0; i < mw; i++) sb_push("read_memd", B_RD_MEMD, 1'b1, 1'b0, 1'b0, 16'h0);
      sb_push("read_memd", B_RD_MEMD, 1'b1, 1'b1, 1'b0, 16'h0);
      push_res(data_out_memd);
    end else if (opc == OP_PUSH_I) begin
      sb_push("prep_imm", 17'h0, 1'b1, 1'b1, 1'b0, 16'h0);
      push_res({5'b0, opnd});
    end else if (opc == OP_PUSH_T) begin
      sb_push("prep_temp", B_RD_T1, 1'b1, 1'b1, 1'b0, 16'h0);
      push_res(temp1_q);
    end else if (opc >= OP_POP && opc <= OP_NOT) begin
      if (m_tos == 0) trap(3'd2);
      else begin
        sb_push("pop_a", B_POP, 1'b1, 1'b1, 1'b0, 16'h0);
        m_tos--;
        sb_push("save_a", B_WR_T1, 1'b1, 1'b1, 1'b0, 16'h0);
        if (opc == OP_POP) begin
          for (int i = 0; i < mw; i++) sb_push("write_memd", B_WR_MEMD, 1'b1, 1'b0, 1'b0, 16'h0);
          sb_push("write_memd", B_WR_MEMD, 1'b1, 1'b1, 1'b0, 16'h0);
          inc_ip_cyc();
        end else begin
          ok = 1'b1;
          if (opc != OP_NOT) begin
            if (m_tos == 0) begin trap(3'd2); ok = 1'b0; end
            else begin
              sb_push("pop_b", B_POP, 1'b1, 1'b1, 1'b0, 16'h0);
              m_tos--;
              sb_push("save_b", B_WR_T2, 1'b1, 1'b1, 1'b0, 16'h0);
            end
          end
          if (ok) begin
            sb_push("exec", B_ALU_EN, 1'b1, 1'b1, 1'b0, 16'h0);
            if (opc == OP_CMP) inc_ip_cyc();
            else push_res(alu_result);
          end
        end
      end
    end else if (opc == OP_GOTO) begin
      sb_push("jump", B_WR_IP, 1'b1, 1'b1, 1'b0, 16'h0);
    end else if (opc >= OP_IF_EQ && opc <= OP_IF_LE) begin
      case (opc)
        OP_IF_EQ: take = flag_eq;
        OP_IF_GT: take = flag_gt;
        OP_IF_LT: take = flag_lt;
        OP_IF_GE: take = flag_eq | flag_gt;
        default:  take = flag_eq | flag_lt;
      endcase
      sb_push("branch", 17'h0, 1'b1, 1'b1, 1'b0, 16'h0);
      if (take) sb_push("branch_jump", B_WR_IP, 1'b1, 1'b1, 1'b0, 16'h0);
      else inc_ip_cyc();
    end else if (opc == OP_CALL) begin
      if (m_rtn == RTN_DEPTH) trap(3'd3);
      else begin
        sb_push("push_rtn", B_PUSH_R | B_RD_IP, 1'b1, 1'b1, 1'b0, 16'h0);
        m_rtn++;
        sb_push("call_jump", B_WR_IP, 1'b1, 1'b1, 1'b0, 16'h0);
      end
    end else if (opc == OP_RET) begin
      if (m_rtn == 0) trap(3'd4);
      else begin
        sb_push("pop_rtn", B_POP_R, 1'b1, 1'b1, 1'b0, 16'h0);
        m_rtn--;
        sb_push("load_ret", B_WR_IP | B_IP_SRC, 1'b1, 1'b1, 1'b0, 16'h0);
        inc_ip_cyc();
      end
    end else if (opc == OP_HALT) begin
      m_halted = 1'b1;
      repeat (3) sb_push("halt", 17'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    end else begin
      trap(3'd5);
    end
    drain();
    post_checks(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    q_exp.delete(); q_drv.delete();
    check("reset strobes", 32'(w_strb), 32'(B_RST_ALL));
    check("reset tos_pointer", 32'(tos_pointer), 32'd0);
    check("reset rtn_pointer", 32'(rtn_pointer), 32'd0);
    check("reset stack_data", 32'(stack_data), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset fault_code", 32'(fault_code), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    m_tos = 0; m_rtn = 0; m_fault = 1'b0; m_code = 3'd0; m_halted = 1'b0;
    rst = 1'b0;
    sb_push("reset_all", B_RST_ALL, 1'b1, 1'b1, 1'b0, 16'h0);
    drain();
  endtask

  initial begin
    rst = 1'b1; instruction = 5'd0; operand = 11'd0;
    mem_ready = 1'b1; memd_ready = 1'b1;
    data_out_memd = 16'h0; temp1_q = 16'h0; alu_result = 16'h0;
    flag_eq = 1'b0; flag_gt = 1'b0; flag_lt = 1'b0;

    do_reset();
    issue(OP_PUSH_I, 11'h7FF, 0, 0);

    do_reset();
    alu_result = 16'd7;
    issue(OP_PUSH_I, 11'd3, 0, 0);
    issue(OP_PUSH_I, 11'd4, 0, 0);
    issue(OP_ADD, 11'd0, 0, 0);
    alu_result = 16'h1234;
    issue(OP_NOT, 11'd0, 0, 0);
    issue(OP_PUSH_I, 11'd9, 0, 0);
    issue(OP_CMP, 11'd0, 0, 0);
    temp1_q = 16'hA5C3;
    issue(OP_PUSH_T, 11'd0, 0, 0);
    issue(OP_POP, 11'h020, 0, 2);
    issue(OP_GOTO, 11'h100, 0, 0);
    issue(OP_PUSH_I, 11'h005, 2, 0);
    issue(OP_ADD, 11'd0, 0, 0);

    do_reset();
    issue(OP_POP, 11'd0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("trap hold fault", 32'(fault), 32'd1);
      check("trap hold code", 32'(fault_code), 32'd2);
      check("trap hold strobes", 32'(w_strb), 32'd0);
    end
    #3 rst = 1'b1;
    #1;
    check("async rst fault", 32'(fault), 32'd0);
    check("async rst code", 32'(fault_code), 32'd0);
    check("async rst strobes", 32'(w_strb), 32'(B_RST_ALL));

    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(OP_PUSH_I, 11'(i + 1), 0, 0);
    issue(OP_PUSH_I, 11'h3FF, 0, 0);

    do_reset();
    issue(OP_CALL, 11'h040, 0, 0);
    issue(OP_RET, 11'd0, 0, 0);
    issue(OP_RET, 11'd0, 0, 0);

    do_reset();
    data_out_memd = 16'hBEEF;
    issue(OP_PUSH, 11'h010, 0, 3);

    do_reset();
    flag_eq = 1'b1;
    issue(OP_IF_GE, 11'h055, 0, 0);
    flag_eq = 1'b0;
    issue(OP_IF_GE, 11'h055, 0, 0);
    flag_lt = 1'b1;
    issue(OP_IF_LE, 11'h066, 0, 0);
    issue(OP_IF_LT, 11'h066, 0, 0);
    issue(OP_IF_GT, 11'h066, 0, 0);
    flag_lt = 1'b0; flag_gt = 1'b1;
    issue(OP_IF_EQ, 11'h077, 0, 0);
    issue(OP_IF_GT, 11'h077, 0, 0);
    flag_gt = 1'b0;

    do_reset();
    for (int i = 0; i < RTN_DEPTH; i++) issue(OP_CALL, 11'(i), 0, 0);
    issue(OP_CALL, 11'h7AA, 0, 0);

    do_reset();
    issue(OP_PUSH_I, 11'd1, 0, 0);
    issue(OP_ADD, 11'd0, 0, 0);

    do_reset();
    issue(5'd22, 11'd0, 0, 0);

    do_reset();
    issue(OP_HALT, 11'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
